// File: rtl/jtkcpu_busctl.sv
// Bus-cycle controller between the KCPU core and external memory: clock-enable
// generation plus a single-transaction bus FSM. Optional timeout: JTKCPU_BUSCTL_TOUT_EN.
module jtkcpu_busctl #(
  parameter int AW     = 24,
  parameter int DW     = 8,
  parameter int PHASES = 2,
  parameter int WAIT_W = 4,
  parameter int TOUT   = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen2,
  output logic              cen_out,
  output logic              cpu_cen,
  input  logic              req,
  input  logic              we_in,
  input  logic [AW-1:0]     addr_in,
  input  logic [DW-1:0]     wdata,
  output logic              ack,
  output logic [DW-1:0]     rdata,
  input  logic              halt,
  input  logic [WAIT_W-1:0] wait_cfg,
  output logic [AW-1:0]     addr,
  output logic [DW-1:0]     dout,
  input  logic [DW-1:0]     din,
  output logic              we,
  output logic              as,
  input  logic              dtack,
  output logic              bus_err
);

  localparam int PH_W = (PHASES > 2) ? $clog2(PHASES) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASES - 1);
  localparam bit CFG_OK = (PHASES >= 2) && (PHASES <= 8) && (TOUT >= 1) && (TOUT <= 65535);

  // An out-of-range parameter set leaves a g_bad_cfg scope visible in the hierarchy.
  generate
    if (!CFG_OK) begin : g_bad_cfg
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, DATA, ERR} state_t;

  state_t            state, state_next;
  logic [PH_W-1:0]   phase, phase_next;
  logic [WAIT_W-1:0] wait_cnt, wait_next;
  logic              stall;
  logic              last_phase;
  logic              cen_out_next, cpu_cen_next;
  logic              ack_next, we_next, as_next;
  logic [AW-1:0]     addr_next;
  logic [DW-1:0]     dout_next, rdata_next;

`ifdef JTKCPU_BUSCTL_TOUT_EN
  localparam logic [15:0] TOUT_LAST = 16'(TOUT - 1);
  logic [15:0] tout_cnt, tout_next;
  logic        bus_err_next;
`else
  assign bus_err = 1'b0;
`endif

  assign last_phase = (phase == PH_LAST);

  // The core only freezes while the bus is really waiting or while halted between accesses.
  assign stall = ((state == WAIT) && ((wait_cnt != '0) || !dtack)) ||
                 ((state == IDLE) && halt);

  always_comb begin
    state_next   = state;
    phase_next   = phase;
    wait_next    = wait_cnt;
    addr_next    = addr;
    dout_next    = dout;
    we_next      = we;
    as_next      = as;
    rdata_next   = rdata;
    ack_next     = 1'b0;
    cen_out_next = cen2 & ~stall;
    cpu_cen_next = cen2 & ~stall & last_phase;
`ifdef JTKCPU_BUSCTL_TOUT_EN
    tout_next    = tout_cnt;
    bus_err_next = 1'b0;
`endif

    if (cen2 && !stall) begin
      phase_next = last_phase ? '0 : phase + 1'b1;
    end

    case (state)
      IDLE: begin
        if (cpu_cen && req && !halt) begin
          addr_next  = addr_in;
          we_next    = we_in;
          dout_next  = wdata;
          as_next    = 1'b1;
          state_next = ADDR;
        end
      end
      ADDR: begin
        if (cen2) begin
          wait_next  = wait_cfg;
`ifdef JTKCPU_BUSCTL_TOUT_EN
          tout_next  = '0;
`endif
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cen2) begin
          if (wait_cnt != '0) begin
            wait_next = wait_cnt - 1'b1;
          end else if (dtack) begin
            state_next = DATA;
          end else begin
`ifdef JTKCPU_BUSCTL_TOUT_EN
            if (tout_cnt != 16'hFFFF) tout_next = tout_cnt + 1'b1;
            if (tout_cnt >= TOUT_LAST) state_next = ERR;
`endif
          end
        end
      end
      DATA: begin
        if (!we) rdata_next = din;
        ack_next   = 1'b1;
        as_next    = 1'b0;
        we_next    = 1'b0;
        state_next = IDLE;
      end
      ERR: begin
        rdata_next   = '1;
        ack_next     = 1'b1;
`ifdef JTKCPU_BUSCTL_TOUT_EN
        bus_err_next = 1'b1;
`endif
        as_next      = 1'b0;
        we_next      = 1'b0;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      phase    <= '0;
      wait_cnt <= '0;
      cen_out  <= 1'b0;
      cpu_cen  <= 1'b0;
      ack      <= 1'b0;
      rdata    <= '0;
      addr     <= '0;
      dout     <= '0;
      we       <= 1'b0;
      as       <= 1'b0;
`ifdef JTKCPU_BUSCTL_TOUT_EN
      tout_cnt <= '0;
      bus_err  <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      phase    <= phase_next;
      wait_cnt <= wait_next;
      cen_out  <= cen_out_next;
      cpu_cen  <= cpu_cen_next;
      ack      <= ack_next;
      rdata    <= rdata_next;
      addr     <= addr_next;
      dout     <= dout_next;
      we       <= we_next;
      as       <= as_next;
`ifdef JTKCPU_BUSCTL_TOUT_EN
      tout_cnt <= tout_next;
      bus_err  <= bus_err_next;
`endif
    end
  end

endmodule

// File: tb/tb_jtkcpu_busctl.sv
// Directed bench for jtkcpu_busctl: enables, read, write with waits, halt,
// async reset abort and dtack stretch (or timeout when JTKCPU_BUSCTL_TOUT_EN is set).
module tb_jtkcpu_busctl;
  localparam int AW = 24, DW = 8, PHASES = 2, WAIT_W = 4;
`ifdef JTKCPU_BUSCTL_TOUT_EN
  localparam int TOUT = 4;
`else
  localparam int TOUT = 255;
`endif

  logic              clk = 1'b0;
  logic              rst_n, cen2, req, we_in, halt, dtack;
  logic [AW-1:0]     addr_in;
  logic [DW-1:0]     wdata, din;
  logic [WAIT_W-1:0] wait_cfg;
  logic              cen_out, cpu_cen, ack, we, as, bus_err;
  logic [DW-1:0]     rdata, dout;
  logic [AW-1:0]     addr;

  int vectors = 0;
  int miscompares = 0;

  jtkcpu_busctl #(.AW(AW), .DW(DW), .PHASES(PHASES), .WAIT_W(WAIT_W), .TOUT(TOUT)) dut (
    .clk(clk), .rst_n(rst_n), .cen2(cen2), .cen_out(cen_out), .cpu_cen(cpu_cen),
    .req(req), .we_in(we_in), .addr_in(addr_in), .wdata(wdata), .ack(ack),
    .rdata(rdata), .halt(halt), .wait_cfg(wait_cfg), .addr(addr), .dout(dout),
    .din(din), .we(we), .as(as), .dtack(dtack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic e_cen, input logic e_cpu,
                         input logic e_as, input logic e_ack);
    chk({tag, ".cen_out"}, 32'(cen_out), 32'(e_cen));
    chk({tag, ".cpu_cen"}, 32'(cpu_cen), 32'(e_cpu));
    chk({tag, ".as"},      32'(as),      32'(e_as));
    chk({tag, ".ack"},     32'(ack),     32'(e_ack));
  endtask

  initial begin
    rst_n = 1'b0; cen2 = 1'b1; req = 1'b0; we_in = 1'b0; halt = 1'b0; dtack = 1'b0;
    addr_in = '0; wdata = '0; din = '0; wait_cfg = '0;

    // Reset state
    tick(); tick();
    chk_bus("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.we", 32'(we), 32'h0);
    chk("rst.addr", 32'(addr), 32'h0);
    chk("rst.dout", 32'(dout), 32'h0);
    chk("rst.rdata", 32'(rdata), 32'h0);
    chk("rst.bus_err", 32'(bus_err), 32'h0);
    rst_n = 1'b1;

    // Free-running enables, no request: cpu_cen every second clk
    for (int n = 1; n <= 4; n++) begin
      tick();
      chk_bus($sformatf("free%0d", n), 1'b1, (n % 2 == 0), 1'b0, 1'b0);
    end

    // Read, zero wait states, dtack already high
    addr_in = 24'h12_3456; we_in = 1'b0; din = 8'hA5; dtack = 1'b1; wait_cfg = 4'd0; req = 1'b1;
    tick();
    chk_bus("rd.addr", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("rd.addr_out", 32'(addr), 32'h12_3456);
    chk("rd.we", 32'(we), 32'h0);
    req = 1'b0;
    tick(); chk_bus("rd.wait", 1'b1, 1'b1, 1'b1, 1'b0);
    tick(); chk_bus("rd.data", 1'b1, 1'b0, 1'b1, 1'b0);
    tick(); chk_bus("rd.ack", 1'b1, 1'b1, 1'b0, 1'b1);
    chk("rd.rdata", 32'(rdata), 32'hA5);
    $display("txn read  addr=%h rdata=%h", addr, rdata);
    tick(); chk("rd.ack_off", 32'(ack), 32'h0);
    chk("rd.rdata_hold", 32'(rdata), 32'hA5);

    // Write with 3 wait states; wait_cfg changed mid-access must not matter
    addr_in = 24'h00_0042; we_in = 1'b1; wdata = 8'h3C; din = 8'h77; wait_cfg = 4'd3; req = 1'b1;
    tick(); chk_bus("wr.pre", 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); chk_bus("wr.addr", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("wr.we", 32'(we), 32'h1);
    chk("wr.dout", 32'(dout), 32'h3C);
    chk("wr.addr_out", 32'(addr), 32'h42);
    req = 1'b0;
    tick(); chk_bus("wr.wait0", 1'b1, 1'b1, 1'b1, 1'b0);
    wait_cfg = 4'd0;
    for (int n = 1; n <= 3; n++) begin
      tick();
      chk_bus($sformatf("wr.ws%0d", n), 1'b0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("wr.ws%0d.we", n), 32'(we), 32'h1);
    end
    tick(); chk_bus("wr.data", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("wr.data.we", 32'(we), 32'h1);
    tick(); chk_bus("wr.ack", 1'b1, 1'b1, 1'b0, 1'b1);
    chk("wr.ack.we", 32'(we), 32'h0);
    chk("wr.rdata_kept", 32'(rdata), 32'hA5);
    $display("txn write addr=%h dout=%h", addr, dout);
    tick(); chk("wr.ack_off", 32'(ack), 32'h0);

    // Halt raised mid-WAIT: access completes, then no new access while halted
    addr_in = 24'h00_ABCD; we_in = 1'b0; din = 8'hC3; wait_cfg = 4'd2; req = 1'b1;
    tick(); chk_bus("hl.pre", 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); chk_bus("hl.addr", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("hl.addr_out", 32'(addr), 32'h00_ABCD);
    tick(); chk_bus("hl.wait0", 1'b1, 1'b1, 1'b1, 1'b0);
    halt = 1'b1;
    tick(); chk_bus("hl.ws1", 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); chk_bus("hl.ws2", 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); chk_bus("hl.data", 1'b1, 1'b0, 1'b1, 1'b0);
    tick(); chk_bus("hl.ack", 1'b1, 1'b1, 1'b0, 1'b1);
    chk("hl.rdata", 32'(rdata), 32'hC3);
    $display("txn read  addr=%h rdata=%h (halt raised mid-access)", addr, rdata);
    for (int n = 1; n <= 4; n++) begin
      tick();
      chk_bus($sformatf("hl.held%0d", n), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    halt = 1'b0; addr_in = 24'h00_FEDC; we_in = 1'b1; wdata = 8'h99; wait_cfg = 4'd0;
    tick(); chk_bus("hl.rel1", 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); chk_bus("hl.rel2", 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); chk_bus("ab.addr", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("ab.we", 32'(we), 32'h1);
    chk("ab.addr_out", 32'(addr), 32'h00_FEDC);
    chk("ab.dout", 32'(dout), 32'h99);
    tick(); chk_bus("ab.wait", 1'b1, 1'b1, 1'b1, 1'b0);
    req = 1'b0;

    // Asynchronous reset mid-access clears everything at once
    rst_n = 1'b0;
    #2;
    chk_bus("ab.rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ab.rst.we", 32'(we), 32'h0);
    chk("ab.rst.addr", 32'(addr), 32'h0);
    $display("txn write addr=00fedc aborted by reset");
    tick(); tick();
    chk_bus("ab.held", 1'b0, 1'b0, 1'b0, 1'b0);

    // Stretched access: dtack low in WAIT
    addr_in = 24'h00_0077; we_in = 1'b0; din = 8'h5A; dtack = 1'b0; wait_cfg = 4'd0; req = 1'b1;
    rst_n = 1'b1;
    tick(); chk_bus("dt.b1", 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); chk_bus("dt.b2", 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); chk_bus("dt.addr", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("dt.addr_out", 32'(addr), 32'h77);
    req = 1'b0;
    tick(); chk_bus("dt.wait0", 1'b1, 1'b1, 1'b1, 1'b0);
`ifdef JTKCPU_BUSCTL_TOUT_EN
    for (int n = 1; n <= 4; n++) begin
      tick();
      chk_bus($sformatf("to.w%0d", n), 1'b0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("to.w%0d.bus_err", n), 32'(bus_err), 32'h0);
    end
    tick(); chk_bus("to.ack", 1'b1, 1'b0, 1'b0, 1'b1);
    chk("to.bus_err", 32'(bus_err), 32'h1);
    chk("to.rdata", 32'(rdata), 32'hFF);
    $display("txn read  addr=%h timeout rdata=%h", addr, rdata);
    tick(); chk("to.ack_off", 32'(ack), 32'h0);
    chk("to.bus_err_off", 32'(bus_err), 32'h0);
`else
    for (int n = 1; n <= 10; n++) begin
      tick();
      chk_bus($sformatf("dt.w%0d", n), 1'b0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("dt.w%0d.bus_err", n), 32'(bus_err), 32'h0);
    end
    dtack = 1'b1;
    tick(); chk_bus("dt.data", 1'b1, 1'b0, 1'b1, 1'b0);
    tick(); chk_bus("dt.ack", 1'b1, 1'b1, 1'b0, 1'b1);
    chk("dt.rdata", 32'(rdata), 32'h5A);
    chk("dt.bus_err", 32'(bus_err), 32'h0);
    $display("txn read  addr=%h rdata=%h (dtack stretched)", addr, rdata);
    tick(); chk("dt.ack_off", 32'(ack), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
